// File: rtl/sdram_burst_scheduler.sv
// Arbitrates four FIFO streams (two camera writers, two VGA readers) onto a single
// SDRAM burst command port, keeping one wrapping address pointer per stream.
module sdram_burst_scheduler #(
  parameter int unsigned ADDR_W = 23,
  parameter int unsigned LVL_W  = 10,
  parameter int unsigned BURST  = 80,
  parameter int unsigned SPAN   = 153600,
  parameter int unsigned BASE_A = 0,
  parameter int unsigned BASE_B = 32'h100000,
  parameter int unsigned RD_TH  = 256
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_load,
  input  logic [LVL_W-1:0]  i_wr_lvl [0:1],
  input  logic [LVL_W-1:0]  i_rd_lvl [0:1],
  output logic              o_cmd_valid,
  input  logic              i_cmd_ready,
  output logic              o_cmd_write,
  output logic [ADDR_W-1:0] o_cmd_addr,
  output logic [8:0]        o_cmd_len,
  input  logic              i_done,
  output logic [3:0]        o_grant,
  output logic              o_busy,
  output logic [1:0]        o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_ADV   = 2'd3
  } state_t;

  localparam logic [LVL_W:0]    BURST_LVL = (LVL_W+1)'(BURST);
  localparam logic [LVL_W:0]    RD_TH_LVL = (LVL_W+1)'(RD_TH);
  localparam logic [ADDR_W-1:0] BASE_A_W  = ADDR_W'(BASE_A);
  localparam logic [ADDR_W-1:0] BASE_B_W  = ADDR_W'(BASE_B);
  localparam logic [ADDR_W:0]   STEP      = (ADDR_W+1)'(BURST);
  localparam logic [ADDR_W:0]   LIM_A     = (ADDR_W+1)'(BASE_A + SPAN);
  localparam logic [ADDR_W:0]   LIM_B     = (ADDR_W+1)'(BASE_B + SPAN);
  localparam logic [8:0]        LEN       = 9'(BURST);

  // Stream index: 0 = WR_A, 1 = WR_B, 2 = RD_A, 3 = RD_B (matches o_grant bit order).
  state_t            state_q, state_d;
  logic              cmd_valid_q, cmd_valid_d;
  logic              cmd_write_q, cmd_write_d;
  logic [ADDR_W-1:0] cmd_addr_q, cmd_addr_d;
  logic [8:0]        cmd_len_q, cmd_len_d;
  logic [3:0]        grant_q, grant_d;
  logic [ADDR_W-1:0] ptr_q [0:3];
  logic [ADDR_W-1:0] ptr_d [0:3];
  logic              pend_q, pend_d;
  logic              last_wr_q, last_wr_d;
  logic              last_rd_q, last_rd_d;

  logic [1:0]        wr_req;
  logic [1:0]        rd_req;
  logic              win_any;
  logic [1:0]        win_idx;

  function automatic logic [ADDR_W-1:0] base_of(input logic is_b);
    return is_b ? BASE_B_W : BASE_A_W;
  endfunction

  function automatic logic [ADDR_W-1:0] step_ptr(input logic [ADDR_W-1:0] p,
                                                  input logic is_b);
    logic [ADDR_W:0] nxt;
    logic [ADDR_W:0] lim;
    nxt = {1'b0, p} + STEP;
    lim = is_b ? LIM_B : LIM_A;
    if (nxt >= lim) return base_of(is_b);
    return nxt[ADDR_W-1:0];
  endfunction

  // Reads beat writes; a tie inside a class goes to the side not served last.
  always_comb begin
    wr_req[0] = {1'b0, i_wr_lvl[0]} >= BURST_LVL;
    wr_req[1] = {1'b0, i_wr_lvl[1]} >= BURST_LVL;
    rd_req[0] = {1'b0, i_rd_lvl[0]} <  RD_TH_LVL;
    rd_req[1] = {1'b0, i_rd_lvl[1]} <  RD_TH_LVL;
    win_any   = (|rd_req) | (|wr_req);
    win_idx   = 2'd0;
    if (|rd_req) begin
      win_idx[1] = 1'b1;
      win_idx[0] = (&rd_req) ? ~last_rd_q : rd_req[1];
    end else if (|wr_req) begin
      win_idx[1] = 1'b0;
      win_idx[0] = (&wr_req) ? ~last_wr_q : wr_req[1];
    end
  end

  // Command handshake: o_cmd_valid rises with stable write/addr/len/grant and they
  // stay frozen until the cycle i_cmd_ready is seen high; exactly one accept per burst.
  always_comb begin
    state_d     = state_q;
    cmd_valid_d = cmd_valid_q;
    cmd_write_d = cmd_write_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_len_d   = cmd_len_q;
    grant_d     = grant_q;
    pend_d      = pend_q;
    last_wr_d   = last_wr_q;
    last_rd_d   = last_rd_q;
    for (int i = 0; i < 4; i++) ptr_d[i] = ptr_q[i];

    if (i_load && (state_q != S_IDLE)) pend_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (i_load || pend_q) begin
          for (int i = 0; i < 4; i++) ptr_d[i] = base_of(i == 1 || i == 3);
          pend_d = 1'b0;
        end else if (win_any) begin
          state_d     = S_ISSUE;
          cmd_valid_d = 1'b1;
          cmd_write_d = ~win_idx[1];
          cmd_addr_d  = ptr_q[win_idx];
          cmd_len_d   = LEN;
          grant_d     = 4'b0001 << win_idx;
          if (win_idx[1]) last_rd_d = ~last_rd_q;
          else            last_wr_d = ~last_wr_q;
        end
      end
      S_ISSUE: begin
        if (i_cmd_ready) begin
          cmd_valid_d = 1'b0;
          state_d     = S_WAIT;
        end
      end
      S_WAIT: begin
        if (i_done) state_d = S_ADV;
      end
      S_ADV: begin
        // A pending load still lets the advance happen; the next IDLE rewinds anyway.
        for (int i = 0; i < 4; i++) begin
          if (grant_q[i]) ptr_d[i] = step_ptr(ptr_q[i], i == 1 || i == 3);
        end
        grant_d = 4'b0000;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= S_IDLE;
      cmd_valid_q <= 1'b0;
      cmd_write_q <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_len_q   <= '0;
      grant_q     <= '0;
      pend_q      <= 1'b0;
      last_wr_q   <= 1'b1;
      last_rd_q   <= 1'b1;
      ptr_q[0]    <= BASE_A_W;
      ptr_q[1]    <= BASE_B_W;
      ptr_q[2]    <= BASE_A_W;
      ptr_q[3]    <= BASE_B_W;
    end else begin
      state_q     <= state_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_write_q <= cmd_write_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_len_q   <= cmd_len_d;
      grant_q     <= grant_d;
      pend_q      <= pend_d;
      last_wr_q   <= last_wr_d;
      last_rd_q   <= last_rd_d;
      for (int i = 0; i < 4; i++) ptr_q[i] <= ptr_d[i];
    end
  end

  assign o_cmd_valid = cmd_valid_q;
  assign o_cmd_write = cmd_write_q;
  assign o_cmd_addr  = cmd_addr_q;
  assign o_cmd_len   = cmd_len_q;
  assign o_grant     = grant_q;
  assign o_busy      = (state_q != S_IDLE);
  assign o_dbg_state = state_q;

endmodule

// File: tb/tb_sdram_burst_scheduler.sv
// Directed bench for sdram_burst_scheduler: a vector table of single bursts plus
// hand sequences for stall, load-in-WAIT, pointer wrap and reset-in-WAIT.
module tb_sdram_burst_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        load;
  logic [9:0]  wr_lvl [0:1];
  logic [9:0]  rd_lvl [0:1];
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [22:0] cmd_addr;
  logic [8:0]  cmd_len;
  logic        done;
  logic [3:0]  grant;
  logic        busy;
  logic [1:0]  dbg_state;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int          wr0, wr1, rd0, rd1;
    int          rdy_dly, done_dly;
    logic [3:0]  grant;
    logic        write;
    logic [22:0] addr;
  } vec_t;

  vec_t vecs [10];
  vec_t v;

  always #5 clk = ~clk;

  sdram_burst_scheduler dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_load      (load),
    .i_wr_lvl    (wr_lvl),
    .i_rd_lvl    (rd_lvl),
    .o_cmd_valid (cmd_valid),
    .i_cmd_ready (cmd_ready),
    .o_cmd_write (cmd_write),
    .o_cmd_addr  (cmd_addr),
    .o_cmd_len   (cmd_len),
    .i_done      (done),
    .o_grant     (grant),
    .o_busy      (busy),
    .o_dbg_state (dbg_state)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic set_lvls(input int w0, input int w1, input int r0, input int r1);
    wr_lvl[0] = 10'(w0);
    wr_lvl[1] = 10'(w1);
    rd_lvl[0] = 10'(r0);
    rd_lvl[1] = 10'(r1);
  endtask

  task automatic idle_lvls();
    set_lvls(0, 0, 300, 300);
  endtask

  task automatic wait_valid(input string name);
    int n;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!cmd_valid && n < 30);
    chk(name, 32'(cmd_valid), 32'd1);
  endtask

  task automatic accept(input logic [3:0] exp_grant);
    cmd_ready = 1'b1;
    @(posedge clk); #1;
    cmd_ready = 1'b0;
    chk("acc_valid_low", 32'(cmd_valid), 32'd0);
    chk("acc_state_wait", 32'(dbg_state), 32'd2);
    chk("acc_grant_held", 32'(grant), 32'(exp_grant));
  endtask

  task automatic pulse_done(input int dly);
    repeat (dly - 1) begin
      @(posedge clk); #1;
    end
    done = 1'b1;
    @(posedge clk); #1;
    done = 1'b0;
    chk("done_state_adv", 32'(dbg_state), 32'd3);
  endtask

  task automatic finish_txn();
    @(posedge clk); #1;
    chk("fin_grant_clr", 32'(grant), 32'd0);
    chk("fin_busy_low", 32'(busy), 32'd0);
  endtask

  task automatic run_vec(input string name, input vec_t tv);
    set_lvls(tv.wr0, tv.wr1, tv.rd0, tv.rd1);
    wait_valid(name);
    idle_lvls();
    chk("grant", 32'(grant), 32'(tv.grant));
    chk("write", 32'(cmd_write), 32'(tv.write));
    chk("addr", 32'(cmd_addr), 32'(tv.addr));
    chk("len", 32'(cmd_len), 32'd80);
    chk("busy", 32'(busy), 32'd1);
    for (int k = 0; k < tv.rdy_dly; k++) begin
      @(posedge clk); #1;
      chk("stall_valid", 32'(cmd_valid), 32'd1);
      chk("stall_addr", 32'(cmd_addr), 32'(tv.addr));
      chk("stall_grant", 32'(grant), 32'(tv.grant));
    end
    accept(tv.grant);
    pulse_done(tv.done_dly);
    finish_txn();
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // wr0 wr1 rd0 rd1 rdy done grant write addr
    vecs[0] = '{80,  0, 300, 300, 0, 5, 4'b0001, 1'b1, 23'h000000};
    vecs[1] = '{80, 80, 300, 300, 7, 2, 4'b0010, 1'b1, 23'h100000};
    vecs[2] = '{80, 80, 300, 300, 0, 1, 4'b0001, 1'b1, 23'h000050};
    vecs[3] = '{80, 80,   0,   0, 0, 1, 4'b0100, 1'b0, 23'h000000};
    vecs[4] = '{80, 80,   0,   0, 0, 1, 4'b1000, 1'b0, 23'h100000};
    vecs[5] = '{80, 80,   0,   0, 0, 1, 4'b0100, 1'b0, 23'h000050};
    vecs[6] = '{80, 80,   0,   0, 0, 1, 4'b1000, 1'b0, 23'h100050};
    vecs[7] = '{ 0,  0, 256, 100, 2, 3, 4'b1000, 1'b0, 23'h1000a0};
    vecs[8] = '{ 0,  0, 255, 256, 0, 1, 4'b0100, 1'b0, 23'h0000a0};
    vecs[9] = '{80, 79, 256, 256, 0, 1, 4'b0001, 1'b1, 23'h0000a0};

    rst = 1'b1; load = 1'b0; cmd_ready = 1'b0; done = 1'b0;
    idle_lvls();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_valid", 32'(cmd_valid), 32'd0);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_addr", 32'(cmd_addr), 32'd0);
    chk("rst_len", 32'(cmd_len), 32'd0);

    for (int i = 0; i < 10; i++) run_vec("vec_valid", vecs[i]);

    // Load while WAIT: burst finishes, one silent IDLE cycle, then rewound pointers.
    set_lvls(400, 0, 300, 300);
    wait_valid("load_valid");
    chk("load_addr_pre", 32'(cmd_addr), 32'h0000f0);
    accept(4'b0001);
    load = 1'b1;
    @(posedge clk); #1;
    load = 1'b0;
    pulse_done(2);
    @(posedge clk); #1;
    chk("load_idle_valid", 32'(cmd_valid), 32'd0);
    @(posedge clk); #1;
    chk("load_rewind_no_cmd", 32'(cmd_valid), 32'd0);
    chk("load_rewind_state", 32'(dbg_state), 32'd0);
    wait_valid("load_post_valid");
    idle_lvls();
    chk("load_post_addr", 32'(cmd_addr), 32'd0);
    chk("load_post_grant", 32'(grant), 32'd1);
    accept(4'b0001);
    pulse_done(1);
    finish_txn();

    // RD_B through a full region and one more burst to see the wrap.
    set_lvls(0, 0, 300, 0);
    for (int i = 0; i <= 1920; i++) begin
      wait_valid("wrap_valid");
      chk("wrap_addr", 32'(cmd_addr), 32'h100000 + 32'((i % 1920) * 80));
      accept(4'b1000);
      pulse_done(1);
      finish_txn();
    end
    idle_lvls();

    // Reset in WAIT, then a stray done must be ignored.
    set_lvls(0, 0, 300, 0);
    wait_valid("rstw_valid");
    idle_lvls();
    chk("rstw_addr", 32'(cmd_addr), 32'h100050);
    accept(4'b1000);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rstw_valid0", 32'(cmd_valid), 32'd0);
    chk("rstw_write0", 32'(cmd_write), 32'd0);
    chk("rstw_addr0", 32'(cmd_addr), 32'd0);
    chk("rstw_len0", 32'(cmd_len), 32'd0);
    chk("rstw_grant0", 32'(grant), 32'd0);
    chk("rstw_busy0", 32'(busy), 32'd0);
    done = 1'b1;
    @(posedge clk); #1;
    done = 1'b0;
    chk("rstw_done_ignored", 32'(dbg_state), 32'd0);
    chk("rstw_done_busy", 32'(busy), 32'd0);

    v = '{0, 0, 0, 0, 0, 1, 4'b0100, 1'b0, 23'h000000};
    run_vec("post_rst_rda", v);
    v = '{0, 0, 0, 0, 0, 1, 4'b1000, 1'b0, 23'h100000};
    run_vec("post_rst_rdb", v);
    v = '{80, 0, 300, 300, 0, 1, 4'b0001, 1'b1, 23'h000000};
    run_vec("post_rst_wra", v);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sdram_burst_scheduler.md
SDRAM_BURST_SCHEDULER -- requirements
Module: sdram_burst_scheduler

Interface
REQ-001 SHALL have parameter ADDR_W, default 23, SDRAM word-address width.
REQ-002 SHALL have parameter LVL_W, default 10, FIFO fill-level width.
REQ-003 SHALL have parameter BURST, default 80, words per burst, also the o_cmd_len value.
REQ-004 SHALL have parameter SPAN, default 153600 (640*480/2), words per frame region; it is a multiple of BURST.
REQ-005 SHALL have parameter BASE_A, default 0, start address of region A (G-high/B words).
REQ-006 SHALL have parameter BASE_B, default 23'h100000, start address of region B (G-low/R words).
REQ-007 SHALL have parameter RD_TH, default 256, read-FIFO level below which a refill is requested.
REQ-008 SHALL have port i_clk, input, 1: sole clock.
REQ-009 SHALL have port i_rst, input, 1: synchronous active-high reset.
REQ-010 SHALL have port i_load, input, 1: frame restart request; rewinds all four address pointers.
REQ-011 SHALL have port i_wr_lvl[0:1], input, 2xLVL_W: words held in write FIFO A and write FIFO B (camera side).
REQ-012 SHALL have port i_rd_lvl[0:1], input, 2xLVL_W: words held in read FIFO A and read FIFO B (VGA side).
REQ-013 SHALL have port o_cmd_valid, output, 1: burst command offered to SDRAM core.
REQ-014 SHALL have port i_cmd_ready, input, 1: core accepts the command this cycle.
REQ-015 SHALL have port o_cmd_write, output, 1: 1 = write burst, 0 = read burst.
REQ-016 SHALL have port o_cmd_addr, output, ADDR_W: burst start address.
REQ-017 SHALL have port o_cmd_len, output, 9: burst length.
REQ-018 SHALL have port i_done, input, 1: one-cycle pulse from the core marking burst completion.
REQ-019 SHALL have port o_grant, output, 4: one-hot {RD_B, RD_A, WR_B, WR_A} FIFO-mux select.
REQ-020 SHALL have port o_busy, output, 1: high in any state other than IDLE.

Function
REQ-021 SHALL implement a four-state FSM: IDLE, ISSUE, WAIT, ADV.
REQ-022 Request conditions: WR_x requests when i_wr_lvl[x] >= BURST; RD_x requests when i_rd_lvl[x] < RD_TH.
REQ-023 Priority: reads over writes; within each class, round-robin between A and B using a per-class last-served bit that toggles on each grant in that class; both last-served bits reset to B, so A wins first.
REQ-024 IDLE, at least one request and no pending load: register the winner, enter ISSUE next cycle; o_cmd_valid, o_grant, o_cmd_write, o_cmd_addr and o_cmd_len are valid that same cycle (1-cycle latency).
REQ-025 ISSUE: outputs held stable while o_cmd_valid=1 and i_cmd_ready=0; on i_cmd_ready=1, deassert o_cmd_valid next cycle and enter WAIT.
REQ-026 WAIT: o_grant held; on i_done=1 enter ADV; i_done in IDLE/ISSUE/ADV ignored.
REQ-027 ADV (one cycle): granted pointer += BURST; if the result >= base+SPAN it wraps to base; clear o_grant; return to IDLE.
REQ-028 Four independent pointers: WR_A/RD_A start at BASE_A, WR_B/RD_B start at BASE_B; address arithmetic is ADDR_W bits unsigned.
REQ-029 i_load in IDLE rewinds all pointers to base the next cycle with no command issued that cycle; i_load in any other state sets a pending flag, the current burst completes normally (ADV advance then overridden), and the rewind occurs in the following IDLE cycle.
REQ-030 When a request and i_load (or a pending load) coincide in IDLE, the load takes precedence and arbitration resumes the cycle after.
REQ-031 Request inputs are sampled only in IDLE; level changes elsewhere have no effect.

Reset
REQ-032 Synchronous i_rst, asserted at any state (including mid-burst), forces next cycle: state IDLE, o_cmd_valid=0, o_cmd_write=0, o_cmd_addr=0, o_cmd_len=0, o_grant=0, o_busy=0, pointers at their bases, pending load cleared, last-served bits = B.

Verification
REQ-033 Reset, i_wr_lvl[0]=80, others idle, i_cmd_ready=1, i_done 5 cycles later -> cmd write, addr 0, len 80, grant 0001; WR_A pointer = 80.
REQ-034 All four requesting, always ready, immediate done -> grant order 0100, 1000, 0100, 1000 while reads stay below RD_TH; writes served only after read levels >= 256.
REQ-035 Drive RD_B through 1920 bursts -> last addr 23'h100000+153520, next addr 23'h100000 (wrap).
REQ-036 i_cmd_ready low 7 cycles -> o_cmd_valid, addr, grant stable all 7 cycles; single accept.
REQ-037 i_load pulsed in WAIT with WR_A at 400 -> burst completes, then all pointers at base, next WR_A command addr 0.
REQ-038 i_rst in WAIT -> next cycle all outputs zero, busy 0; a following i_done is ignored.
